// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, FSM state codes and digit validity check
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
    return nibble <= DIGIT_W'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: combinational single-digit BCD subtract with borrow in/out
import bcd_pkg::*;
module bcd_digit_sub (
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);
  logic [DIGIT_W:0] t;
  always_comb begin
    t = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT_W{1'b0}}, bin};
    bout = t[DIGIT_W];
    d = t[DIGIT_W-1:0] + (bout ? DIGIT_W'(10) : DIGIT_W'(0));
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: packed-BCD A-B, one digit per clock LSD first, valid/ready handshakes
import bcd_pkg::*;
module bcd_serial_subtractor #(
  parameter int DIGITS = 4,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow_out,
  output logic                  err
);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [4*DIGITS-1:0] a_r, b_r;
  logic borrow, bad, bout;
  logic [DIGIT_W-1:0] d;
  assign in_ready = state != CALC && state != DONE;
  assign out_valid = state == DONE;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | !is_bcd(a[DIGIT_W*i +: DIGIT_W]) | !is_bcd(b[DIGIT_W*i +: DIGIT_W]);
  end
  bcd_digit_sub u_sub (
    .a_d (a_r[DIGIT_W*int'(cnt) +: DIGIT_W]),
    .b_d (b_r[DIGIT_W*int'(cnt) +: DIGIT_W]),
    .bin (borrow),
    .d   (d),
    .bout(bout)
  );
  // An errored operation still walks every digit so latency is data-independent; its result stays zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      borrow <= 1'b0;
      diff <= '0;
      borrow_out <= 1'b0;
      err <= 1'b0;
    end else if (in_ready) begin
      state <= in_valid ? CALC : IDLE;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
        cnt <= '0;
        borrow <= 1'b0;
        diff <= '0;
        borrow_out <= 1'b0;
        err <= bad;
      end
    end else if (state == CALC) begin
      diff[DIGIT_W*int'(cnt) +: DIGIT_W] <= err ? '0 : d;
      borrow <= bout;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(DIGITS-1)) begin
        state <= DONE;
        cnt <= '0;
        borrow_out <= bout & ~err;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: randomized and directed checks against a decimal-arithmetic model
module tb_bcd_serial_subtractor;
  localparam int DIGITS = 4;
  localparam int W = 4*DIGITS;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, borrow_out, err;
  logic [W-1:0] diff;
  int checks = 0, failures = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: convert to integers, subtract, wrap negatives modulo 10**DIGITS, convert back.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] ed, output logic eb, output logic ee);
    int ia, ib, r, m;
    logic [3:0] na, nb;
    ia = 0; ib = 0; m = 1; ee = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      na = av[4*i +: 4];
      nb = bv[4*i +: 4];
      if (na > 9 || nb > 9) ee = 1'b1;
      ia = ia*10 + int'(na);
      ib = ib*10 + int'(nb);
      m = m*10;
    end
    r = ia - ib;
    eb = r < 0;
    if (eb) r = r + m;
    ed = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ed[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (ee) begin
      ed = '0;
      eb = 1'b0;
    end
  endfunction

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
    logic [W-1:0] ed;
    logic eb, ee;
    int n;
    model(av, bv, ed, eb, ee);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL %s in_ready timeout got %b exp 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    checks++;
    if (n !== DIGITS) begin failures++; $display("FAIL %s latency got %0d exp %0d", name, n, DIGITS); end
    checks++;
    if (diff !== ed) begin failures++; $display("FAIL %s diff got %h exp %h", name, diff, ed); end
    checks++;
    if (borrow_out !== eb) begin failures++; $display("FAIL %s borrow_out got %b exp %b", name, borrow_out, eb); end
    checks++;
    if (err !== ee) begin failures++; $display("FAIL %s err got %b exp %b", name, err, ee); end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release got out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({in_ready, out_valid, diff, borrow_out, err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset got in_ready=%b out_valid=%b diff=%h borrow=%b err=%b exp 1 0 0000 0 0",
               in_ready, out_valid, diff, borrow_out, err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    do_op(16'h1234, 16'h0567, "basic");
    do_op(16'h0100, 16'h0001, "ripple");
    do_op(16'h5555, 16'h5555, "equal");
    do_op(16'h0000, 16'h0001, "under_all9");
    do_op(16'h0003, 16'h0010, "under_9993");
    do_op(16'h12A4, 16'h0001, "err_a");
    do_op(16'h0001, 16'hF000, "err_b");
    do_op(16'h9999, 16'h0000, "max");
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < DIGITS; i++) begin
        av[4*i +: 4] = 4'($urandom_range(0, 9));
        bv[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) av[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(av, bv, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed;
    logic eb, ee;
    int n;
    model(16'h0987, 16'h0123, ed, eb, ee);
    a = 16'h0987; b = 16'h0123; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    for (int k = 0; k < 6; k++) begin
      a = 16'h9999; b = 16'h0000; in_valid = 1'b1;
      checks++;
      if ({out_valid, in_ready, diff, borrow_out} !== {1'b1, 1'b0, ed, eb}) begin
        failures++;
        $display("FAIL hold got out_valid=%b in_ready=%b diff=%h borrow=%b exp 1 0 %h %b",
                 out_valid, in_ready, diff, borrow_out, ed, eb);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    do_op(16'h0500, 16'h0501, "after_bp");
  endtask

  task automatic test_mid_reset();
    a = 16'h1234; b = 16'h0567; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0) begin
      failures++;
      $display("FAIL mid_reset got in_ready=%b out_valid=%b diff=%h exp 1 0 0000", in_ready, out_valid, diff);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || diff !== '0) begin
      failures++;
      $display("FAIL mid_reset_discard got out_valid=%b diff=%h exp 0 0000", out_valid, diff);
    end
    do_op(16'h0042, 16'h0017, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
